// File: rtl/riscv32_fetch_unit.sv
// rtl/riscv32_fetch_unit.sv - RV32I instruction fetch front-end with prefetch FIFO and redirect handling
// Optional perf counters: define RISCV32_FETCH_PERF_CNT_EN to add perf_starve_cycles / perf_flush_count.
module riscv32_fetch_unit #(
  parameter int                  WORD_LEN   = 32,
  parameter logic [WORD_LEN-1:0] START_ADDR = '0,
  parameter int                  FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic                out_valid,
  output logic [WORD_LEN-1:0] out_inst,
  output logic [WORD_LEN-1:0] out_pc,
  input  logic                out_ready,
  input  logic                redirect,
  input  logic [WORD_LEN-1:0] redirect_pc
`ifdef RISCV32_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_starve_cycles,
  output logic [31:0]         perf_flush_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Request channel state: the registered request is what the bus sees.
  logic                req_q;
  logic [WORD_LEN-1:0] req_addr_q;
  logic [WORD_LEN-1:0] fetch_pc_q;
  logic                stale_q;

  // Response bookkeeping.
  logic [CNT_W-1:0]    outstanding_q;
  logic [CNT_W-1:0]    drop_cnt_q;
  logic [WORD_LEN-1:0] resp_pc_q;

  // Prefetch FIFO.
  logic [WORD_LEN-1:0] inst_mem [FIFO_DEPTH];
  logic [WORD_LEN-1:0] pc_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [CNT_W-1:0]    fifo_count_q;

  // Next-state values.
  logic                grant;
  logic                push;
  logic                pop;
  logic                resp_drop;
  logic [WORD_LEN-1:0] target_pc;
  logic [CNT_W-1:0]    outstanding_nxt;
  logic [CNT_W-1:0]    fifo_count_nxt;
  logic [CNT_W-1:0]    drop_cnt_nxt;
  logic [CNT_W:0]      credit_used;
  logic                stale_nxt;
  logic                req_nxt;
  logic [WORD_LEN-1:0] req_addr_nxt;
  logic [WORD_LEN-1:0] fetch_pc_nxt;
  logic [WORD_LEN-1:0] resp_pc_nxt;

  // The two low target bits are architecturally meaningless for word fetch.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign imem_req  = req_q;
  assign imem_addr = req_addr_q;

  // Head of FIFO drives the core; zeros while nothing is buffered.
  assign out_valid = (fifo_count_q != '0);
  assign out_inst  = out_valid ? inst_mem[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q]   : '0;

  // Combinational event decode and next-state computation for all counters.
  always_comb begin
    grant     = req_q && imem_gnt;
    target_pc = {redirect_pc[WORD_LEN-1:2], 2'b00};
    resp_drop = imem_rvalid && (drop_cnt_q != '0);
    // A redirect swallows a response landing in the same cycle, and blocks pop.
    push      = imem_rvalid && (drop_cnt_q == '0) && !redirect;
    pop       = out_valid && out_ready && !redirect;

    outstanding_nxt = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);

    if (redirect) begin
      fifo_count_nxt = '0;
    end else begin
      fifo_count_nxt = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // drop_cnt tracks in-flight responses that belong to an abandoned path.
    if (redirect) begin
      drop_cnt_nxt = outstanding_nxt;
      stale_nxt    = req_q && !imem_gnt;
    end else begin
      drop_cnt_nxt = drop_cnt_q - CNT_W'(resp_drop) + CNT_W'(stale_q && grant);
      stale_nxt    = stale_q && !grant;
    end

    // A stale grant does not advance fetch_pc; it already points at the target.
    if (redirect) begin
      fetch_pc_nxt = target_pc;
    end else if (grant && !stale_q) begin
      fetch_pc_nxt = fetch_pc_q + WORD_LEN'(4);
    end else begin
      fetch_pc_nxt = fetch_pc_q;
    end

    if (redirect) begin
      resp_pc_nxt = target_pc;
    end else if (push) begin
      resp_pc_nxt = resp_pc_q + WORD_LEN'(4);
    end else begin
      resp_pc_nxt = resp_pc_q;
    end

    // Credits: in-flight plus buffered words never exceed the FIFO size.
    credit_used = {1'b0, outstanding_nxt} + {1'b0, fifo_count_nxt};
    if (req_q && !imem_gnt) begin
      req_nxt      = 1'b1;
      req_addr_nxt = req_addr_q;
    end else begin
      req_nxt      = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
      req_addr_nxt = fetch_pc_nxt;
    end
  end

  // Control and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q         <= 1'b0;
      req_addr_q    <= START_ADDR;
      fetch_pc_q    <= START_ADDR;
      resp_pc_q     <= START_ADDR;
      stale_q       <= 1'b0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_count_q  <= '0;
    end else begin
      req_q         <= req_nxt;
      req_addr_q    <= req_addr_nxt;
      fetch_pc_q    <= fetch_pc_nxt;
      resp_pc_q     <= resp_pc_nxt;
      stale_q       <= stale_nxt;
      outstanding_q <= outstanding_nxt;
      drop_cnt_q    <= drop_cnt_nxt;
      fifo_count_q  <= fifo_count_nxt;
    end
  end

  // FIFO pointers; a flush simply rewinds both to the same slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by out_valid.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

`ifdef RISCV32_FETCH_PERF_CNT_EN
  // Performance counters: core starvation cycles and pipeline flushes.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_starve_cycles <= '0;
      perf_flush_count   <= '0;
    end else begin
      if (!out_valid && out_ready) begin
        perf_starve_cycles <= perf_starve_cycles + 32'd1;
      end
      if (redirect) begin
        perf_flush_count <= perf_flush_count + 32'd1;
      end
    end
  end
`endif

endmodule
